// File: rtl/counter_ctrl.sv
// Wishbone-mapped up-counter with compare match, one-shot stop and interrupt.
// The count register can also be loaded from the logic-analyzer port.
module counter_ctrl #(
  parameter int unsigned BITS      = 32,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_i,
  input  logic [BITS-1:0] la_data_i,
  output logic [BITS-1:0] count_o,
  output logic            irq_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} bus_state_t;

  bus_state_t      state_r;
  logic            en_r, oneshot_r, irq_en_r, match_r;
  logic [BITS-1:0] count_r, cmp_r;

  logic            valid_s, accept_s, wr_s;
  logic [1:0]      off_s;
  logic            wr_ctrl_s, wr_count_s, wr_cmp_s, wr_status_s;
  logic            load_s, hit_s, en_next_s, match_next_s;
  logic [BITS-1:0] count_next_s, count_wr_s, cmp_wr_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  function automatic logic [31:0] widen(input logic [BITS-1:0] v);
    logic [31:0] r;
    r          = 32'd0;
    r[BITS-1:0] = v;
    return r;
  endfunction

  // Byte-lane merge; lanes beyond BITS fall off in the final truncation.
  function automatic logic [BITS-1:0] lane_merge(input logic [BITS-1:0] old_val,
                                                 input logic [31:0]     new_val,
                                                 input logic [3:0]      sel);
    logic [31:0] r;
    r = widen(old_val);
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : r[8*i +: 8];
    end
    return r[BITS-1:0];
  endfunction

  assign unused_s = ^wbs_adr_i[1:0];
  assign count_o  = count_r;

  // Request decode, next-state and read-mux logic.
  always_comb begin
    valid_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    accept_s    = valid_s & (state_r == ST_IDLE);
    wr_s        = accept_s & wbs_we_i;
    off_s       = wbs_adr_i[3:2];
    wr_ctrl_s   = wr_s & (off_s == 2'd0);
    wr_count_s  = wr_s & (off_s == 2'd1);
    wr_cmp_s    = wr_s & (off_s == 2'd2);
    wr_status_s = wr_s & (off_s == 2'd3);
    count_wr_s  = lane_merge(count_r, wbs_dat_i, wbs_sel_i);
    cmp_wr_s    = lane_merge(cmp_r, wbs_dat_i, wbs_sel_i);
    load_s      = wr_count_s | la_load_i;
    hit_s       = en_r & ~load_s & (count_r == cmp_r);

    if (wr_count_s) begin
      count_next_s = count_wr_s;
    end else if (la_load_i) begin
      count_next_s = la_data_i;
    end else if (en_r & ~(hit_s & oneshot_r)) begin
      count_next_s = count_r + {{(BITS-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end

    // A bus write to EN overrides the one-shot auto-stop on the same edge.
    if (wr_ctrl_s & wbs_sel_i[0]) begin
      en_next_s = wbs_dat_i[0];
    end else if (hit_s & oneshot_r) begin
      en_next_s = 1'b0;
    end else begin
      en_next_s = en_r;
    end

    if (hit_s) begin
      match_next_s = 1'b1;
    end else if (wr_status_s & wbs_sel_i[0] & wbs_dat_i[0]) begin
      match_next_s = 1'b0;
    end else begin
      match_next_s = match_r;
    end

    case (off_s)
      2'd0:    rdata_s = {29'd0, irq_en_r, oneshot_r, en_r};
      2'd1:    rdata_s = widen(count_r);
      2'd2:    rdata_s = widen(cmp_r);
      2'd3:    rdata_s = {30'd0, en_r, match_r};
      default: rdata_s = 32'd0;
    endcase
  end

  // Bus FSM, register file and registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r   <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      irq_en_r  <= 1'b0;
      count_r   <= {BITS{1'b0}};
      cmp_r     <= {BITS{1'b1}};
      match_r   <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? 32'd0 : rdata_s;
          end else begin
            state_r   <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
          end
        end
        ST_ACK: begin
          state_r   <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'd0;
        end
        default: begin
          state_r   <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'd0;
        end
      endcase

      if (wr_ctrl_s & wbs_sel_i[0]) begin
        oneshot_r <= wbs_dat_i[1];
        irq_en_r  <= wbs_dat_i[2];
      end else begin
        oneshot_r <= oneshot_r;
        irq_en_r  <= irq_en_r;
      end

      if (wr_cmp_s) begin
        cmp_r <= cmp_wr_s;
      end else begin
        cmp_r <= cmp_r;
      end

      en_r    <= en_next_s;
      count_r <= count_next_s;
      match_r <= match_next_s;
      irq_o   <= match_r & irq_en_r;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: per-cycle comparison against a transaction-level
// model of the register map, plus literal expectations at key points.
module tb_counter_ctrl;

  localparam int unsigned BITS      = 16;
  localparam logic [31:0] ADDR_BASE = 32'h3000_0000;
  localparam logic [31:0] MASK      = (32'd1 << BITS) - 32'd1;

  logic            clk, rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic            la_load;
  logic [BITS-1:0] la_data;
  logic [BITS-1:0] count;
  logic            irq;

  int errors = 0;
  int checks = 0;

  counter_ctrl #(.BITS(BITS), .ADDR_BASE(ADDR_BASE)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .wbs_cyc_i(cyc),     .wbs_stb_i(stb),    .wbs_we_i(we),
    .wbs_sel_i(sel),     .wbs_adr_i(adr),    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),     .wbs_dat_o(rdat),
    .la_load_i(la_load), .la_data_i(la_data),
    .count_o  (count),   .irq_o    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        en, os, ie, match, irq, ack, rd;
    logic [31:0] count, cmp, dat;
  } mstate_t;

  mstate_t m;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r & MASK;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r     = '0;
    r.cmp = MASK;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic c, input logic st,
                                   input logic w, input logic [3:0] sl, input logic [31:0] a,
                                   input logic [31:0] d, input logic ld, input logic [31:0] ldv);
    mstate_t n;
    logic    take, wrc, hit;
    int      off;
    n    = s;
    take = !s.ack && c && st && (a[31:4] == ADDR_BASE[31:4]);
    off  = int'(a[3:2]);
    n.ack = take;
    n.rd  = take && !w;
    n.dat = 32'd0;
    if (take && !w) begin
      if (off == 0) n.dat = {29'd0, s.ie, s.os, s.en};
      if (off == 1) n.dat = s.count;
      if (off == 2) n.dat = s.cmp;
      if (off == 3) n.dat = {30'd0, s.en, s.match};
    end
    wrc = take && w && off == 1;
    hit = s.en && !wrc && !ld && s.count == s.cmp;
    if (wrc) n.count = merge(s.count, d, sl);
    else if (ld) n.count = ldv & MASK;
    else if (s.en && !(hit && s.os)) n.count = (s.count + 32'd1) & MASK;
    if (hit && s.os) n.en = 1'b0;
    if (take && w && off == 0 && sl[0]) begin
      n.en = d[0]; n.os = d[1]; n.ie = d[2];
    end
    if (take && w && off == 2) n.cmp = merge(s.cmp, d, sl);
    if (take && w && off == 3 && sl[0] && d[0]) n.match = 1'b0;
    if (hit) n.match = 1'b1;
    n.irq = s.match && s.ie;
    return n;
  endfunction

  // Advance the model on every edge using the inputs the DUT saw.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= step(m, cyc, stb, we, sel, adr, wdat, la_load, 32'(la_data));
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc_ack",   32'(ack),   32'(m.ack));
    chk("cyc_count", 32'(count), m.count);
    chk("cyc_irq",   32'(irq),   32'(m.irq));
    if (!m.ack || m.rd) chk("cyc_dat", rdat, m.dat);
  end

  // ---------------- bus helpers (called at negedge, return at negedge) ----------------
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic acked);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; r = 32'd0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; r = rdat; end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; logic a;
    bus(1'b1, ADDR_BASE + {28'd0, off, 2'b00}, d, s, r, a);
    chk("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rd(input string nm, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] r; logic a;
    bus(1'b0, ADDR_BASE + {28'd0, off, 2'b00}, 32'd0, 4'h0, r, a);
    chk({nm, "_ack"}, 32'(a), 32'd1);
    chk(nm, r, exp);
  endtask

  task automatic wait_count(input logic [31:0] v);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (32'(count) == v) hit = 1'b1;
      else @(negedge clk);
    end
    chk("wait_count", 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; logic a;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; wdat = 32'd0; la_load = 1'b0; la_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_irq",   32'(irq),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd("rst_cmp", 2'd2, 32'h0000_FFFF);
    rd("rst_ctrl", 2'd0, 32'd0);

    // Free-running count with a non-stopping match.
    wr(2'd2, 32'd5, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    for (int i = 0; i < 20 && count != 16'd5; i++) begin @(posedge clk); #1; end
    chk("run_at5", 32'(count), 32'd5);
    @(posedge clk); #1;
    chk("run_past5", 32'(count), 32'd6);
    @(negedge clk);
    rd("run_status", 2'd3, 32'h3);
    wr(2'd0, 32'h0, 4'hF);
    wr(2'd3, 32'h1, 4'hF);

    // One-shot with interrupt, then W1C.
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd2, 32'd3, 4'hF);
    wr(2'd0, 32'h7, 4'hF);
    repeat (8) @(negedge clk);
    chk("os_hold", 32'(count), 32'd3);
    chk("os_irq",  32'(irq),   32'd1);
    rd("os_status", 2'd3, 32'h1);
    rd("os_ctrl",   2'd0, 32'h6);
    wr(2'd3, 32'h1, 4'h1);
    @(posedge clk); #1;
    chk("w1c_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rd("w1c_status", 2'd3, 32'h0);
    wr(2'd0, 32'h0, 4'hF);

    // Match set coincides with W1C: set wins.
    wr(2'd2, 32'h30, 4'hF);
    wr(2'd1, 32'h2D, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    wait_count(32'h30);
    wr(2'd3, 32'h1, 4'h1);
    rd("setwins_status", 2'd3, 32'h3);
    wr(2'd0, 32'h0, 4'hF);
    wr(2'd3, 32'h1, 4'hF);

    // CTRL write on the one-shot stop edge: write keeps EN set.
    wr(2'd2, 32'h50, 4'hF);
    wr(2'd1, 32'h4D, 4'hF);
    wr(2'd0, 32'h3, 4'hF);
    wait_count(32'h50);
    wr(2'd0, 32'h1, 4'hF);
    chk("wrwins_hold", 32'(count), 32'h50);
    @(posedge clk); #1;
    chk("wrwins_run", 32'(count), 32'h51);
    @(negedge clk);
    wr(2'd0, 32'h0, 4'hF);
    wr(2'd3, 32'h1, 4'hF);

    // Wrap from all-ones to zero with no match.
    wr(2'd2, 32'h10, 4'hF);
    wr(2'd1, 32'hFFFF, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    chk("wrap_pre", 32'(count), 32'hFFFF);
    @(posedge clk); #1;
    chk("wrap_zero", 32'(count), 32'h0);
    @(negedge clk);
    rd("wrap_status", 2'd3, 32'h2);
    wr(2'd0, 32'h0, 4'hF);

    // WB write to COUNT beats a simultaneous LA load.
    la_data = 16'h0040; la_load = 1'b1;
    wr(2'd1, 32'h20, 4'hF);
    chk("prio_wb", 32'(count), 32'h20);
    @(posedge clk); #1;
    chk("prio_la", 32'(count), 32'h40);
    @(negedge clk);
    la_load = 1'b0;

    // Byte lanes, lanes above BITS, out-of-window request.
    wr(2'd2, 32'h0, 4'hF);
    wr(2'd2, 32'hAABB_CCDD, 4'b0010);
    rd("sel_cmp", 2'd2, 32'h0000_CC00);
    wr(2'd2, 32'h0011_0000, 4'b0100);
    rd("sel_high", 2'd2, 32'h0000_CC00);
    bus(1'b1, ADDR_BASE + 32'h10, 32'h7, 4'hF, r, a);
    chk("oow_ack", 32'(a), 32'd0);
    rd("oow_ctrl", 2'd0, 32'h0);

    // Asynchronous reset during the ACK cycle.
    wr(2'd2, 32'd2, 4'hF);
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h5, 4'hF);
    repeat (6) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ADDR_BASE; sel = 4'hF;
    @(posedge clk); #1;
    chk("pre_rst_ack", 32'(ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ack",   32'(ack),   32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_irq",   32'(irq),   32'd0);
    chk("arst_dat",   rdat,       32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd("post_rst_ctrl", 2'd0, 32'h0);
    rd("post_rst_cmp",  2'd2, 32'h0000_FFFF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
